// File: rtl/rpn_sequencer.sv
// rtl/rpn_sequencer.sv - RPN token sequencer driving an external operand stack
// Operands are pushed directly; operators pop two words, compute, and push the result.
module rpn_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tok_valid,
    output logic                     tok_ready,
    input  logic                     tok_is_op,
    input  logic [WIDTH-1:0]         tok_data,
    output logic                     stk_push,
    output logic                     stk_pop,
    output logic [WIDTH-1:0]         stk_data_in,
    input  logic [WIDTH-1:0]         stk_data_out,
    output logic                     res_valid,
    output logic [WIDTH-1:0]         res_data,
    output logic                     err,
    output logic [$clog2(DEPTH):0]   depth
);

    localparam int DW = $clog2(DEPTH) + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT_B = 3'd1,
        WAIT_A = 3'd2,
        PUSH_R = 3'd3,
        WAIT_R = 3'd4
    } state_t;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_RES = 2'd3;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic             err_q, err_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             accept;

    // State resets asynchronously, so ready needs the raw reset to stay low while held.
    assign tok_ready = rst && (state_q == IDLE);
    assign accept    = tok_valid && tok_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            op_q        <= OP_ADD;
            a_q         <= '0;
            b_q         <= '0;
            depth_q     <= '0;
            err_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            depth_q     <= depth_d;
            err_q       <= err_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        depth_d     = depth_q;
        err_d       = 1'b0;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        stk_push    = 1'b0;
        stk_pop     = 1'b0;
        stk_data_in = '0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!tok_is_op) begin
                        if (depth_q < DW'(DEPTH)) begin
                            stk_push    = 1'b1;
                            stk_data_in = tok_data;
                            depth_d     = depth_q + DW'(1);
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (tok_data[1:0] == OP_RES) begin
                        if (depth_q != '0) begin
                            stk_pop = 1'b1;
                            state_d = WAIT_R;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (depth_q >= DW'(2)) begin
                        stk_pop = 1'b1;
                        op_d    = tok_data[1:0];
                        state_d = WAIT_B;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            // The first pop returns the newer operand (b); the second returns a.
            WAIT_B: begin
                b_d     = stk_data_out;
                stk_pop = 1'b1;
                state_d = WAIT_A;
            end
            WAIT_A: begin
                a_d     = stk_data_out;
                state_d = PUSH_R;
            end
            PUSH_R: begin
                stk_push = 1'b1;
                case (op_q)
                    OP_SUB:  stk_data_in = a_q - b_q;
                    OP_MUL:  stk_data_in = a_q * b_q;
                    default: stk_data_in = a_q + b_q;
                endcase
                depth_d = depth_q - DW'(1);
                state_d = IDLE;
            end
            WAIT_R: begin
                res_data_d  = stk_data_out;
                res_valid_d = 1'b1;
                depth_d     = depth_q - DW'(1);
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign err       = err_q;
    assign depth     = depth_q;

endmodule

// File: tb/tb_rpn_sequencer.sv
// tb/tb_rpn_sequencer.sv - scoreboard bench for rpn_sequencer with a behavioural stack
module tb_rpn_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tok_valid = 1'b0;
    logic       tok_ready;
    logic       tok_is_op = 1'b0;
    logic [7:0] tok_data = '0;
    logic       stk_push, stk_pop;
    logic [7:0] stk_data_in;
    logic [7:0] stk_data_out;
    logic       res_valid;
    logic [7:0] res_data;
    logic       err;
    logic [3:0] depth;

    int n_tests = 0;
    int n_fail  = 0;

    rpn_sequencer #(.WIDTH(8), .DEPTH(8)) dut (
        .clk(clk), .rst(rst),
        .tok_valid(tok_valid), .tok_ready(tok_ready),
        .tok_is_op(tok_is_op), .tok_data(tok_data),
        .stk_push(stk_push), .stk_pop(stk_pop),
        .stk_data_in(stk_data_in), .stk_data_out(stk_data_out),
        .res_valid(res_valid), .res_data(res_data),
        .err(err), .depth(depth)
    );

    always #5 clk = ~clk;

    // Downstream stack: popped word appears on stk_data_out the cycle after stk_pop.
    logic [7:0] mem [0:7];
    int         sp;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp           <= 0;
            stk_data_out <= '0;
        end else if (stk_push && sp < 8) begin
            mem[sp] <= stk_data_in;
            sp      <= sp + 1;
        end else if (stk_pop && sp > 0) begin
            stk_data_out <= mem[sp-1];
            sp           <= sp - 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model and scoreboards
    logic [7:0] ref_stk [0:7];
    int         ref_sp  = 0;
    int         exp_err = 0;
    int         exp_pop = 0;
    int         err_seen = 0;
    int         pop_seen = 0;
    logic [7:0] push_q [$];
    logic [7:0] res_q  [$];

    always @(negedge clk) begin
        if (rst) begin
            if (stk_push && stk_pop) chk("push_pop_excl", 1, 0);
            if (stk_push) begin
                if (push_q.size() == 0) chk("push_unexpected", {24'd0, stk_data_in}, 32'hffff_ffff);
                else chk("push_data", stk_data_in, push_q.pop_front());
            end
            if (stk_pop) pop_seen++;
            if (err) err_seen++;
            if (res_valid) begin
                if (res_q.size() == 0) chk("res_unexpected", {24'd0, res_data}, 32'hffff_ffff);
                else chk("res_data", res_data, res_q.pop_front());
            end
        end
    end

    task automatic send_tok(input logic op, input logic [7:0] d);
        int n;
        int busy;
        logic [7:0] a, b, r;
        n = 0;
        while (!tok_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 20) chk("ready_timeout", 0, 1);
        busy = 0;
        if (!op) begin
            if (ref_sp < 8) begin
                ref_stk[ref_sp] = d; ref_sp++; push_q.push_back(d);
            end else exp_err++;
        end else if (d[1:0] == 2'd3) begin
            if (ref_sp >= 1) begin
                ref_sp--; res_q.push_back(ref_stk[ref_sp]); exp_pop++; busy = 1;
            end else exp_err++;
        end else begin
            if (ref_sp >= 2) begin
                b = ref_stk[ref_sp-1];
                a = ref_stk[ref_sp-2];
                case (d[1:0])
                    2'd0:    r = a + b;
                    2'd1:    r = a - b;
                    default: r = a * b;
                endcase
                ref_sp--; ref_stk[ref_sp-1] = r; push_q.push_back(r);
                exp_pop += 2; busy = 3;
            end else exp_err++;
        end
        tok_valid = 1'b1; tok_is_op = op; tok_data = d;
        @(posedge clk); #1;
        tok_valid = 1'b0; tok_is_op = 1'b0; tok_data = '0;
        n = 0;
        while (!tok_ready && n < 10) begin
            @(posedge clk); #1; n++;
        end
        chk("busy_cycles", n, busy);
    endtask

    task automatic settle(input string tag);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_depth"}, depth, ref_sp);
        chk({tag, "_err"}, err_seen, exp_err);
        chk({tag, "_pops"}, pop_seen, exp_pop);
        chk({tag, "_pushq"}, push_q.size(), 0);
        chk({tag, "_resq"}, res_q.size(), 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", tok_ready, 0);
        chk("rst_depth", depth, 0);
        chk("rst_push", stk_push, 0);
        chk("rst_pop", stk_pop, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rel_ready", tok_ready, 1);
        chk("rel_depth", depth, 0);
        chk("rel_res_valid", res_valid, 0);
        chk("rel_err", err, 0);

        send_tok(0, 8'd3); send_tok(0, 8'd4); send_tok(1, 8'd0); send_tok(1, 8'd3);
        settle("add");
        send_tok(0, 8'd5); send_tok(0, 8'd7); send_tok(1, 8'd1); send_tok(1, 8'd3);
        settle("sub");
        send_tok(0, 8'd20); send_tok(0, 8'd13); send_tok(1, 8'd2); send_tok(1, 8'd3);
        settle("mul");

        for (int i = 1; i <= 8; i++) send_tok(0, 8'(i));
        settle("fill");
        chk("fill_depth8", depth, 8);
        send_tok(0, 8'd9);
        settle("overflow");
        send_tok(1, 8'd3);
        settle("res_top");
        for (int i = 0; i < 7; i++) send_tok(1, 8'd3);
        settle("drain");

        send_tok(0, 8'd1);
        send_tok(1, 8'd0);
        settle("add_underflow");
        chk("add_underflow_depth1", depth, 1);
        send_tok(1, 8'd3);
        send_tok(1, 8'd3);
        settle("res_underflow");

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 0) send_tok(0, 8'($urandom));
            else send_tok(1, 8'($urandom_range(0, 3)));
        end
        settle("random");
        while (ref_sp > 0) send_tok(1, 8'd3);
        settle("random_drain");

        // Reset while the MUL is between its two pops and the result push.
        send_tok(0, 8'd2); send_tok(0, 8'd3);
        settle("pre_reset");
        tok_valid = 1'b1; tok_is_op = 1'b1; tok_data = 8'd2;
        @(posedge clk); #1;
        tok_valid = 1'b0; tok_is_op = 1'b0; tok_data = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_depth", depth, 0);
        chk("mid_rst_push", stk_push, 0);
        chk("mid_rst_pop", stk_pop, 0);
        chk("mid_rst_din", stk_data_in, 0);
        chk("mid_rst_ready", tok_ready, 0);
        chk("mid_rst_res", {res_valid, res_data}, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_pops", pop_seen, exp_pop + 2);
        exp_pop += 2;
        ref_sp = 0;
        push_q.delete();
        res_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", tok_ready, 1);
        settle("post_rst");
        send_tok(0, 8'd9); send_tok(0, 8'd6); send_tok(1, 8'd1); send_tok(1, 8'd3);
        settle("post_rst_sub");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
